// File: rtl/serial_or_reducer_pkg.sv
// Shared types and sizing helpers for the serial OR reducer.
package serial_or_reducer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Reporting the count needs to hold MAX_BEATS itself; termination only needs MAX_BEATS-1.
    function automatic int cnt_width(input int max_beats, input bit with_count);
        return with_count ? $clog2(max_beats + 1) : $clog2(max_beats);
    endfunction

endpackage

// File: rtl/mux.sv
// Single-bit 2:1 multiplexer primitive.
module mux (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/serial_or_reducer_or_word.sv
// Word-wide OR built from 2:1 mux cells: a set select bit forces the output to 1.
module or_word_using_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] new_bits,
    input  logic [WIDTH-1:0] acc_sel,
    output logic [WIDTH-1:0] acc_next
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux u_mux (
            .d0  (new_bits[i]),
            .d1  (1'b1),
            .sel (acc_sel[i]),
            .y   (acc_next[i])
        );
    end
endmodule

// File: rtl/serial_or_reducer.sv
// Reduces each packet of beats to the bitwise OR of its words, with a one-entry result register.
// Optional down_count output enabled by SERIAL_OR_REDUCER_COUNT_EN.
//   state | meaning
//   IDLE  | no partial packet
//   ACCUM | partial packet held in acc
//   HOLD  | result registered, down_valid=1
module serial_or_reducer
    import serial_or_reducer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
`ifdef SERIAL_OR_REDUCER_COUNT_EN
    output logic [$clog2(MAX_BEATS+1)-1:0] down_count,
`endif
    output logic             down_trunc
);
`ifdef SERIAL_OR_REDUCER_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif
    localparam int CNT_W = cnt_width(MAX_BEATS, COUNT_EN);
    localparam logic [CNT_W:0] MAX_B = (CNT_W+1)'(MAX_BEATS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             trunc_q, trunc_d;
    logic [WIDTH-1:0] acc_sel, acc_next;
    logic [CNT_W:0]   cnt_plus;
    logic             accept, finish;

    or_word_using_mux #(.WIDTH(WIDTH)) u_or (
        .new_bits (up_data),
        .acc_sel  (acc_sel),
        .acc_next (acc_next)
    );

    assign up_ready   = (state_q != HOLD) || down_ready;
    assign accept     = up_valid && up_ready;
    assign acc_sel    = (state_q == ACCUM) ? acc_q : '0;
    assign cnt_plus   = {1'b0, cnt_q} + 1'b1;
    assign finish     = up_last || (cnt_plus == MAX_B);
    assign down_valid = (state_q == HOLD);
    assign down_data  = dout_q;
    assign down_trunc = trunc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        trunc_d = trunc_q;
        if (accept) begin
            if (finish) begin
                dout_d  = acc_next;
                trunc_d = !up_last;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = HOLD;
            end else begin
                acc_d   = acc_next;
                cnt_d   = cnt_plus[CNT_W-1:0];
                state_d = ACCUM;
            end
        end else if (state_q == HOLD && down_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            trunc_q <= trunc_d;
        end
    end

`ifdef SERIAL_OR_REDUCER_COUNT_EN
    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    always_comb begin
        dcnt_d = dcnt_q;
        if (accept && finish) dcnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) dcnt_q <= '0;
        else     dcnt_q <= dcnt_d;
    end

    assign down_count = dcnt_q;
`endif

endmodule

// File: tb/tb_serial_or_reducer.sv
// Directed-vector bench for serial_or_reducer (MAX_BEATS=4); checks down_count when SERIAL_OR_REDUCER_COUNT_EN is defined.
module tb_serial_or_reducer;
    logic       clk = 1'b0;
    logic       rst;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic       up_last;
    logic       down_valid;
    logic       down_ready;
    logic [7:0] down_data;
    logic       down_trunc;
`ifdef SERIAL_OR_REDUCER_COUNT_EN
    logic [2:0] down_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    serial_or_reducer #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_last    (up_last),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
`ifdef SERIAL_OR_REDUCER_COUNT_EN
        .down_count (down_count),
`endif
        .down_trunc (down_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        up_valid = 1'b1;
        up_data  = d;
        up_last  = l;
        tick();
        up_valid = 1'b0;
        up_last  = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef SERIAL_OR_REDUCER_COUNT_EN
        chk(tag, 32'(down_count), 32'(exp));
`endif
    endtask

    initial begin
        rst = 1'b1; up_valid = 1'b0; up_data = '0; up_last = 1'b0; down_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 32'(down_valid), 0);
        chk("rst_data",  32'(down_data),  0);
        chk("rst_trunc", 32'(down_trunc), 0);
        chk("rst_ready", 32'(up_ready),   1);
        chk_cnt("rst_count", 0);

        // single-beat packet
        beat(8'h12, 1'b1);
        chk("t1_valid", 32'(down_valid), 1);
        chk("t1_data",  32'(down_data),  32'h12);
        chk("t1_trunc", 32'(down_trunc), 0);
        chk_cnt("t1_count", 1);
        tick();
        chk("t1_drain", 32'(down_valid), 0);

        // three beats with an idle gap in ACCUM
        chk("t2_ready0", 32'(up_ready), 1);
        beat(8'h01, 1'b0);
        chk("t2_ready1", 32'(up_ready), 1);
        chk("t2_nov1",   32'(down_valid), 0);
        tick();
        chk("t2_ready2", 32'(up_ready), 1);
        beat(8'h10, 1'b0);
        chk("t2_ready3", 32'(up_ready), 1);
        beat(8'h80, 1'b1);
        chk("t2_valid", 32'(down_valid), 1);
        chk("t2_data",  32'(down_data),  32'h91);
        chk("t2_trunc", 32'(down_trunc), 0);
        chk_cnt("t2_count", 3);
        tick();
        chk("t2_drain", 32'(down_valid), 0);

        // stall with downstream not ready, then back-to-back replace
        down_ready = 1'b0;
        beat(8'h55, 1'b1);
        chk("t3_valid", 32'(down_valid), 1);
        chk("t3_data",  32'(down_data),  32'h55);
        up_valid = 1'b1; up_data = 8'h04; up_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_ready", 32'(up_ready),   0);
            chk("t3_stall_data",  32'(down_data),  32'h55);
            chk("t3_stall_valid", 32'(down_valid), 1);
            tick();
        end
        down_ready = 1'b1;
        #1;
        chk("t3_pass_ready", 32'(up_ready), 1);
        tick();
        up_valid = 1'b0; up_last = 1'b0;
        chk("t3_b2b_valid", 32'(down_valid), 1);
        chk("t3_b2b_data",  32'(down_data),  32'h04);
        tick();
        chk("t3_drain", 32'(down_valid), 0);

        // forced termination at MAX_BEATS=4, followed by back-to-back tail packet
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h04, 1'b0);
        chk("t4_nov", 32'(down_valid), 0);
        beat(8'h08, 1'b0);
        chk("t4a_valid", 32'(down_valid), 1);
        chk("t4a_data",  32'(down_data),  32'h0F);
        chk("t4a_trunc", 32'(down_trunc), 1);
        chk_cnt("t4a_count", 4);
        beat(8'h20, 1'b1);
        chk("t4b_valid", 32'(down_valid), 1);
        chk("t4b_data",  32'(down_data),  32'h20);
        chk("t4b_trunc", 32'(down_trunc), 0);
        chk_cnt("t4b_count", 1);
        tick();
        chk("t4_drain", 32'(down_valid), 0);

        // reset mid-packet discards the partial accumulation
        beat(8'hF0, 1'b0);
        beat(8'h0F, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_valid", 32'(down_valid), 0);
        tick();
        chk("t5_idle_valid", 32'(down_valid), 0);
        beat(8'h03, 1'b1);
        chk("t5_valid", 32'(down_valid), 1);
        chk("t5_data",  32'(down_data),  32'h03);
        chk("t5_trunc", 32'(down_trunc), 0);
        tick();
        chk("t5_drain", 32'(down_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
